// File: rtl/pwm_carrier_gen.sv
// rtl/pwm_carrier_gen.sv - PWM carrier generator: up/down/up-down counter with prescaler, phase preload and shadowed settings (optional CARRIER_SYNC_OUT_EN adds sync_out)
module pwm_carrier_gen #(
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pwm_onoff,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] init,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] clkdiv,
    input  logic [1:0]           mask_sel,
    input  logic                 sync_in,
    output logic [CNT_WIDTH-1:0] carrier,
    output logic                 dir,
    output logic                 zero_evt,
    output logic                 prd_evt,
    output logic                 maskevent
`ifdef CARRIER_SYNC_OUT_EN
    ,
    output logic                 sync_out
`endif
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UPDN = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] carrier_q, carrier_d;
    logic                 dir_q, dir_d;
    logic                 zero_q, zero_d;
    logic                 prd_q, prd_d;
    logic                 mask_q, mask_d;
    logic [DIV_WIDTH-1:0] psc_q, psc_d;
    logic [CNT_WIDTH-1:0] period_sh_q, period_sh_d;
    logic [1:0]           mode_sh_q, mode_sh_d;
    logic [DIV_WIDTH-1:0] clkdiv_sh_q, clkdiv_sh_d;
    logic [1:0]           mask_sel_sh_q, mask_sel_sh_d;

    logic                 tick;
    logic                 counting;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 next_dir;
    logic [CNT_WIDTH-1:0] stop_val;
    logic [CNT_WIDTH-1:0] sync_val;

    // ">=" so a smaller divider landing mid-prescale cannot strand the prescaler
    assign tick     = (psc_q >= clkdiv_sh_q);
    assign stop_val = (init > period)      ? period      : init;
    assign sync_val = (init > period_sh_q) ? period_sh_q : init;

    // Next carrier value for one tick in the active mode; overshoot of a lowered period resolves at once
    always_comb begin
        next_cnt = carrier_q;
        next_dir = dir_q;
        counting = 1'b1;
        case (mode_sh_q)
            MODE_UP: begin
                next_cnt = (carrier_q >= period_sh_q) ? '0 : carrier_q + CNT_ONE;
                next_dir = 1'b1;
            end
            MODE_DOWN: begin
                next_cnt = (carrier_q == '0 || carrier_q > period_sh_q) ? period_sh_q : carrier_q - CNT_ONE;
                next_dir = 1'b0;
            end
            MODE_UPDN: begin
                if (period_sh_q == '0) begin
                    next_cnt = '0;
                end else if (dir_q) begin
                    if (carrier_q > period_sh_q)
                        next_cnt = period_sh_q;
                    else if (carrier_q == period_sh_q)
                        next_cnt = period_sh_q - CNT_ONE;
                    else
                        next_cnt = carrier_q + CNT_ONE;
                end else begin
                    if (carrier_q == '0)
                        next_cnt = CNT_ONE;
                    else if (carrier_q > period_sh_q)
                        next_cnt = period_sh_q;
                    else
                        next_cnt = carrier_q - CNT_ONE;
                end
                if (next_cnt == '0)
                    next_dir = 1'b1;
                else if (next_cnt == period_sh_q)
                    next_dir = 1'b0;
                else
                    next_dir = (next_cnt > carrier_q);
            end
            default: begin
                counting = 1'b0;
            end
        endcase
    end

    // Next-state selection: stop preload, sync reload, tick step, or prescale
    always_comb begin
        carrier_d     = carrier_q;
        dir_d         = dir_q;
        zero_d        = 1'b0;
        prd_d         = 1'b0;
        mask_d        = 1'b0;
        psc_d         = psc_q;
        period_sh_d   = period_sh_q;
        mode_sh_d     = mode_sh_q;
        clkdiv_sh_d   = clkdiv_sh_q;
        mask_sel_sh_d = mask_sel_sh_q;

        if (!pwm_onoff || mask_q) begin
            period_sh_d   = period;
            mode_sh_d     = mode;
            clkdiv_sh_d   = clkdiv;
            mask_sel_sh_d = mask_sel;
        end

        if (!pwm_onoff) begin
            carrier_d = stop_val;
            dir_d     = (mode != MODE_DOWN);
            psc_d     = '0;
        end else if (sync_in) begin
            carrier_d = sync_val;
            dir_d     = (mode_sh_q != MODE_DOWN);
            psc_d     = '0;
        end else if (tick) begin
            psc_d = '0;
            if (counting) begin
                carrier_d = next_cnt;
                dir_d     = next_dir;
                zero_d    = (next_cnt == '0);
                prd_d     = (next_cnt == period_sh_q);
                mask_d    = (zero_d && (mask_sel_sh_q == 2'b00 || mask_sel_sh_q == 2'b10)) ||
                            (prd_d  && (mask_sel_sh_q == 2'b01 || mask_sel_sh_q == 2'b10));
            end
        end else begin
            psc_d = psc_q + DIV_ONE;
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            carrier_q     <= '0;
            dir_q         <= 1'b1;
            zero_q        <= 1'b0;
            prd_q         <= 1'b0;
            mask_q        <= 1'b0;
            psc_q         <= '0;
            period_sh_q   <= '0;
            mode_sh_q     <= '0;
            clkdiv_sh_q   <= '0;
            mask_sel_sh_q <= '0;
        end else begin
            carrier_q     <= carrier_d;
            dir_q         <= dir_d;
            zero_q        <= zero_d;
            prd_q         <= prd_d;
            mask_q        <= mask_d;
            psc_q         <= psc_d;
            period_sh_q   <= period_sh_d;
            mode_sh_q     <= mode_sh_d;
            clkdiv_sh_q   <= clkdiv_sh_d;
            mask_sel_sh_q <= mask_sel_sh_d;
        end
    end

    assign carrier   = carrier_q;
    assign dir       = dir_q;
    assign zero_evt  = zero_q;
    assign prd_evt   = prd_q;
    assign maskevent = mask_q;

`ifdef CARRIER_SYNC_OUT_EN
    logic sync_out_q;

    // Chaining pulse for a downstream generator's sync_in, aligned with zero_evt
    always_ff @(posedge clk) begin
        if (reset)
            sync_out_q <= 1'b0;
        else
            sync_out_q <= zero_d;
    end

    assign sync_out = sync_out_q;
`endif

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// tb/tb_pwm_carrier_gen.sv - table-driven scoreboard bench for pwm_carrier_gen
module tb_pwm_carrier_gen;

    typedef struct {
        logic        rst;
        logic        on;
        logic [15:0] per;
        logic [15:0] ini;
        logic [1:0]  md;
        logic [7:0]  div;
        logic [1:0]  ms;
        logic        syn;
        logic [15:0] car;
        logic        dr;
        logic        z;
        logic        p;
        logic        m;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_onoff;
    logic [15:0] period;
    logic [15:0] init;
    logic [1:0]  mode;
    logic [7:0]  clkdiv;
    logic [1:0]  mask_sel;
    logic        sync_in;
    logic [15:0] carrier;
    logic        dir;
    logic        zero_evt;
    logic        prd_evt;
    logic        maskevent;
`ifdef CARRIER_SYNC_OUT_EN
    logic        sync_out;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    pwm_carrier_gen #(.CNT_WIDTH(16), .DIV_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_onoff (pwm_onoff),
        .period    (period),
        .init      (init),
        .mode      (mode),
        .clkdiv    (clkdiv),
        .mask_sel  (mask_sel),
        .sync_in   (sync_in),
        .carrier   (carrier),
        .dir       (dir),
        .zero_evt  (zero_evt),
        .prd_evt   (prd_evt),
        .maskevent (maskevent)
`ifdef CARRIER_SYNC_OUT_EN
        ,
        .sync_out  (sync_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic on, input int per, input int ini,
                                input int md, input int div, input int ms, input logic syn,
                                input int car, input logic dr, input logic z, input logic p, input logic m);
        vec_t v;
        v.rst = rst; v.on = on; v.per = per[15:0]; v.ini = ini[15:0];
        v.md = md[1:0]; v.div = div[7:0]; v.ms = ms[1:0]; v.syn = syn;
        v.car = car[15:0]; v.dr = dr; v.z = z; v.p = p; v.m = m;
        vecs.push_back(v);
    endfunction

    function automatic void add_run(input int per, input int ini, input int md, input int div, input int ms,
                                    input int car, input logic dr, input logic z, input logic p, input logic m);
        add(1'b0, 1'b1, per, ini, md, div, ms, 1'b0, car, dr, z, p, m);
    endfunction

    initial begin
        vec_t e;
        vec_t v;
        reset = 1'b1; pwm_onoff = 1'b0; period = '0; init = '0;
        mode = '0; clkdiv = '0; mask_sel = '0; sync_in = 1'b0;

        // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        // up mode P=4
        add(0, 0, 4, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add_run(4, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add_run(4, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add_run(4, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        add_run(4, 0, 0, 0, 0,   4, 1, 0, 1, 0);
        add_run(4, 0, 0, 0, 0,   0, 1, 1, 0, 1);
        add_run(4, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        // stop clamps preload to period
        add(0, 0, 10, 20, 0, 0, 0, 0,   10, 1, 0, 0, 0);
        // down mode from init=3
        add(0, 0, 10, 3, 1, 0, 0, 0,   3, 0, 0, 0, 0);
        add_run(10, 3, 1, 0, 0,   2, 0, 0, 0, 0);
        add_run(10, 3, 1, 0, 0,   1, 0, 0, 0, 0);
        add_run(10, 3, 1, 0, 0,   0, 0, 1, 0, 1);
        add_run(10, 3, 1, 0, 0,  10, 0, 0, 1, 0);
        add_run(10, 3, 1, 0, 0,   9, 0, 0, 0, 0);
        // hold mode
        add(0, 0, 7, 4, 3, 0, 2, 0,   4, 1, 0, 0, 0);
        add_run(7, 4, 3, 0, 2,   4, 1, 0, 0, 0);
        add_run(7, 4, 3, 0, 2,   4, 1, 0, 0, 0);
        add_run(7, 4, 3, 0, 2,   4, 1, 0, 0, 0);
        // P=0
        add(0, 0, 0, 5, 0, 0, 2, 0,   0, 1, 0, 0, 0);
        add_run(0, 5, 0, 0, 2,   0, 1, 1, 1, 1);
        add_run(0, 5, 0, 0, 2,   0, 1, 1, 1, 1);
        // up-down P=3, clkdiv=2, mask both
        add(0, 0, 3, 0, 2, 2, 2, 0,   0, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   0, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   0, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   3, 0, 0, 1, 1);
        add_run(3, 0, 2, 2, 2,   3, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   3, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   2, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 0, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   0, 1, 1, 0, 1);
        add_run(3, 0, 2, 2, 2,   0, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   0, 1, 0, 0, 0);
        add_run(3, 0, 2, 2, 2,   1, 1, 0, 0, 0);
        // shadowed period: written at carrier=3, lands after the zero boundary
        add(0, 0, 10, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add_run(10, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add_run(10, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        for (int i = 4; i <= 9; i++) add_run(5, 0, 0, 0, 0,   i, 1, 0, 0, 0);
        add_run(5, 0, 0, 0, 0,  10, 1, 0, 1, 0);
        add_run(5, 0, 0, 0, 0,   0, 1, 1, 0, 1);
        for (int i = 1; i <= 4; i++) add_run(5, 0, 0, 0, 0,   i, 1, 0, 0, 0);
        add_run(5, 0, 0, 0, 0,   5, 1, 0, 1, 0);
        add_run(5, 0, 0, 0, 0,   0, 1, 1, 0, 1);
        // period lowered below carrier at the period boundary
        add(0, 0, 10, 9, 0, 1, 1, 0,   9, 1, 0, 0, 0);
        add_run(10, 9, 0, 1, 1,   9, 1, 0, 0, 0);
        add_run(10, 9, 0, 1, 1,  10, 1, 0, 1, 1);
        add_run(5, 9, 0, 1, 1,   10, 1, 0, 0, 0);
        add_run(5, 9, 0, 1, 1,    0, 1, 1, 0, 0);
        add_run(5, 9, 0, 1, 1,    0, 1, 0, 0, 0);
        add_run(5, 9, 0, 1, 1,    1, 1, 0, 0, 0);
        // sync reload beats a coincident tick
        add(0, 0, 8, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add_run(8, 6, 0, 0, 0,   1, 1, 0, 0, 0);
        add_run(8, 6, 0, 0, 0,   2, 1, 0, 0, 0);
        add(0, 1, 8, 6, 0, 0, 0, 1,   6, 1, 0, 0, 0);
        add_run(8, 6, 0, 0, 0,   7, 1, 0, 0, 0);
        add_run(8, 6, 0, 0, 0,   8, 1, 0, 1, 0);
        add_run(8, 6, 0, 0, 0,   0, 1, 1, 0, 1);
        add_run(8, 6, 0, 0, 0,   1, 1, 0, 0, 0);
        // reset mid-prescale clears counter, prescaler and shadows
        add(0, 0, 10, 0, 0, 3, 0, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   1, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   1, 1, 0, 0, 0);
        add(1, 1, 10, 0, 0, 3, 0, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 1, 1, 1);
        add_run(10, 0, 0, 3, 0,   0, 1, 1, 1, 1);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   0, 1, 0, 0, 0);
        add_run(10, 0, 0, 3, 0,   1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; pwm_onoff = v.on; period = v.per; init = v.ini;
            mode = v.md; clkdiv = v.div; mask_sel = v.ms; sync_in = v.syn;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({carrier, dir, zero_evt, prd_evt, maskevent} !== {e.car, e.dr, e.z, e.p, e.m}) begin
                errors++;
                $display("FAIL vec%0d: got car=%0d dir=%b z=%b p=%b m=%b, want car=%0d dir=%b z=%b p=%b m=%b",
                         i, carrier, dir, zero_evt, prd_evt, maskevent, e.car, e.dr, e.z, e.p, e.m);
            end
`ifdef CARRIER_SYNC_OUT_EN
            checks++;
            if (sync_out !== e.z) begin
                errors++;
                $display("FAIL sync_out vec%0d: got %b want %b", i, sync_out, e.z);
            end
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
